// File: rtl/clock_pkg.sv
// Shared types and helpers for the BCD time-of-day counter.
package clock_pkg;

    typedef logic [7:0] bcd2_t;

    typedef struct packed {
        bcd2_t hh;
        bcd2_t mm;
        bcd2_t ss;
    } time_bcd_t;

    typedef enum logic [1:0] {
        FLD_SEC  = 2'd0,
        FLD_MIN  = 2'd1,
        FLD_HOUR = 2'd2,
        FLD_NONE = 2'd3
    } field_sel_e;

    localparam bcd2_t MAX_SEC  = 8'h59;
    localparam bcd2_t MAX_MIN  = 8'h59;
    localparam bcd2_t MAX_HOUR = 8'h23;

    // Once both digits are known to be decimal, a plain byte compare orders BCD values correctly.
    function automatic logic bcd2_valid(input bcd2_t value, input bcd2_t max);
        return (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9) && (value <= max);
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that wraps MAX -> 00; priority load > inc > en.
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter bcd2_t MAX       = 8'h59,
    parameter bcd2_t RESET_VAL = 8'h00
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  en,
    input  logic  inc,
    input  logic  load,
    input  bcd2_t load_value,
    output bcd2_t count,
    output bcd2_t count_nxt,
    output logic  carry
);

    function automatic bcd2_t bcd2_incr(input bcd2_t x);
        if (x == MAX)
            return 8'h00;
        else if (x[3:0] == 4'd9)
            return {x[7:4] + 4'd1, 4'd0};
        else
            return {x[7:4], x[3:0] + 4'd1};
    endfunction

    assign carry = en && (count == MAX);

    always_comb begin
        count_nxt = count;
        if (load)
            count_nxt = load_value;
        else if (inc || en)
            count_nxt = bcd2_incr(count);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count <= RESET_VAL;
        else
            count <= count_nxt;
    end

endmodule

// File: rtl/time_counter_sync.sv
// Single-clock HH:MM:SS BCD time-of-day counter with prescaler, validated load,
// per-field adjust, 12/24h display formatting and day-rollover strobe.
module time_counter_sync
    import clock_pkg::*;
#(
    parameter int          CLK_FREQ_HZ = 50_000_000,
    parameter int          TICK_HZ     = 1,
    parameter logic [23:0] RESET_TIME  = 24'h000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        mode_12h,
    input  logic        load,
    input  logic [23:0] load_value,
    input  logic        inc,
    input  logic [1:0]  inc_sel,
    output logic [23:0] value,
    output logic        pm,
    output logic        tick,
    output logic        day_wrap,
    output logic        load_err
);

    localparam int unsigned DIV = CLK_FREQ_HZ / TICK_HZ;
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam time_bcd_t RST = RESET_TIME;

    logic [PW-1:0] presc;
    time_bcd_t     ld, cur, nxt, disp;
    field_sel_e    sel;
    logic          load_ok, accept_load, reject_load, inc_act, adv, tick_c;
    logic          sec_carry, min_carry, hour_carry;

    function automatic bcd2_t to_12h(input bcd2_t hh);
        logic [4:0] bin;
        bin = {1'b0, hh[7:4]} * 5'd10 + {1'b0, hh[3:0]};
        if (bin == 5'd0)
            bin = 5'd12;
        else if (bin > 5'd12)
            bin = bin - 5'd12;
        return (bin >= 5'd10) ? {4'h1, 4'(bin - 5'd10)} : {4'h0, bin[3:0]};
    endfunction

    assign ld  = load_value;
    assign sel = field_sel_e'(inc_sel);

    assign load_ok     = bcd2_valid(ld.hh, MAX_HOUR) && bcd2_valid(ld.mm, MAX_MIN) &&
                         bcd2_valid(ld.ss, MAX_SEC);
    assign accept_load = load && load_ok;
    assign reject_load = load && !load_ok;
    assign inc_act     = !load && inc;
    assign adv         = !load && !inc && run;
    assign tick_c      = adv && (presc == PRESC_LAST);

    bcd_mod_counter #(.MAX(MAX_SEC), .RESET_VAL(RST.ss)) u_sec (
        .clk(clk), .reset(reset), .en(tick_c),
        .inc(inc_act && (sel == FLD_SEC)), .load(accept_load), .load_value(ld.ss),
        .count(cur.ss), .count_nxt(nxt.ss), .carry(sec_carry)
    );

    bcd_mod_counter #(.MAX(MAX_MIN), .RESET_VAL(RST.mm)) u_min (
        .clk(clk), .reset(reset), .en(sec_carry),
        .inc(inc_act && (sel == FLD_MIN)), .load(accept_load), .load_value(ld.mm),
        .count(cur.mm), .count_nxt(nxt.mm), .carry(min_carry)
    );

    bcd_mod_counter #(.MAX(MAX_HOUR), .RESET_VAL(RST.hh)) u_hour (
        .clk(clk), .reset(reset), .en(min_carry),
        .inc(inc_act && (sel == FLD_HOUR)), .load(accept_load), .load_value(ld.hh),
        .count(cur.hh), .count_nxt(nxt.hh), .carry(hour_carry)
    );

    // Display is formatted from next state so value/pm land on the same edge as the state change.
    always_comb begin
        disp = nxt;
        if (mode_12h)
            disp.hh = to_12h(nxt.hh);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc    <= '0;
            value    <= RESET_TIME;
            pm       <= (RST.hh >= 8'h12);
            tick     <= 1'b0;
            day_wrap <= 1'b0;
            load_err <= 1'b0;
        end else begin
            if (accept_load)
                presc <= '0;
            else if (adv)
                presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
            value    <= disp;
            pm       <= (nxt.hh >= 8'h12);
            tick     <= tick_c;
            day_wrap <= hour_carry;
            load_err <= reject_load;
        end
    end

endmodule

// File: tb/tb_time_counter_sync.sv
// Directed self-checking bench for time_counter_sync at DIV = 10.
module tb_time_counter_sync;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        mode_12h = 1'b0;
    logic        load = 1'b0;
    logic [23:0] load_value = '0;
    logic        inc = 1'b0;
    logic [1:0]  inc_sel = 2'd3;
    logic [23:0] value;
    logic        pm, tick, day_wrap, load_err;

    int vectors = 0;
    int miscompares = 0;

    time_counter_sync #(
        .CLK_FREQ_HZ(10),
        .TICK_HZ(1),
        .RESET_TIME(24'h000000)
    ) dut (
        .clk(clk), .reset(reset), .run(run), .mode_12h(mode_12h),
        .load(load), .load_value(load_value), .inc(inc), .inc_sel(inc_sel),
        .value(value), .pm(pm), .tick(tick), .day_wrap(day_wrap), .load_err(load_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [23:0] v);
        load = 1'b1;
        load_value = v;
        step();
        load = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int ticks, wraps, at;
        logic prev, wide;

        // reset state
        #1 reset = 1'b0;
        step(); step();
        check("rst_value", value, 24'h000000);
        check("rst_tick", {23'b0, tick}, 24'd0);
        check("rst_day_wrap", {23'b0, day_wrap}, 24'd0);
        check("rst_load_err", {23'b0, load_err}, 24'd0);
        check("rst_pm", {23'b0, pm}, 24'd0);

        // free run for 30 clocks
        reset = 1'b1;
        run = 1'b1;
        ticks = 0; prev = 1'b0; wide = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (tick) ticks++;
            if (tick && prev) wide = 1'b1;
            prev = tick;
        end
        check("run30_value", value, 24'h000003);
        check("run30_ticks", 24'(ticks), 24'd3);
        check("run30_tick_width", {23'b0, wide}, 24'd0);

        // day rollover
        do_load(24'h235958);
        check("load_235958", value, 24'h235958);
        wraps = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (day_wrap) wraps++;
            if (i == 10) begin
                check("roll_235959", value, 24'h235959);
                check("roll_pm_late", {23'b0, pm}, 24'd1);
            end
        end
        check("roll_000000", value, 24'h000000);
        check("roll_day_wrap_now", {23'b0, day_wrap}, 24'd1);
        check("roll_day_wrap_count", 24'(wraps), 24'd1);
        run = 1'b0;

        // rejected loads
        do_load(24'h126075);
        check("bad_ss_err", {23'b0, load_err}, 24'd1);
        check("bad_ss_value", value, 24'h000000);
        step();
        check("bad_ss_err_clear", {23'b0, load_err}, 24'd0);
        do_load(24'h1A0000);
        check("bad_digit_err", {23'b0, load_err}, 24'd1);
        check("bad_digit_value", value, 24'h000000);

        // per-field increments
        do_load(24'h105959);
        check("good_load_err", {23'b0, load_err}, 24'd0);
        check("load_105959", value, 24'h105959);
        inc = 1'b1; inc_sel = 2'd1;
        step();
        inc = 1'b0;
        check("inc_min_wrap", value, 24'h100059);
        check("inc_min_no_tick", {23'b0, tick}, 24'd0);
        inc = 1'b1; inc_sel = 2'd0;
        step();
        inc = 1'b0;
        check("inc_sec_wrap", value, 24'h100000);
        do_load(24'h230000);
        inc = 1'b1; inc_sel = 2'd2;
        step();
        inc = 1'b0;
        check("inc_hour_wrap", value, 24'h000000);
        check("inc_hour_no_wrap", {23'b0, day_wrap}, 24'd0);

        // 12h display
        mode_12h = 1'b1;
        do_load(24'h001500);
        check("h12_midnight", value, 24'h121500);
        check("h12_midnight_pm", {23'b0, pm}, 24'd0);
        do_load(24'h130500);
        check("h12_1pm", value, 24'h010500);
        check("h12_1pm_pm", {23'b0, pm}, 24'd1);
        do_load(24'h120000);
        check("h12_noon", value, 24'h120000);
        check("h12_noon_pm", {23'b0, pm}, 24'd1);
        do_load(24'h221000);
        check("h12_10pm", value, 24'h101000);
        mode_12h = 1'b0;
        step();
        check("h24_back", value, 24'h221000);

        // pause keeps prescaler phase
        do_load(24'h000000);
        run = 1'b1;
        for (int i = 0; i < 7; i++) step();
        run = 1'b0;
        ticks = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (tick) ticks++;
        end
        check("pause_ticks", 24'(ticks), 24'd0);
        check("pause_value", value, 24'h000000);
        run = 1'b1;
        at = 0;
        for (int i = 1; i <= 5 && at == 0; i++) begin
            step();
            if (tick) at = i;
        end
        check("resume_latency", 24'(at), 24'd3);
        check("resume_value", value, 24'h000001);

        // asynchronous mid-count reset
        for (int i = 0; i < 4; i++) step();
        #2 reset = 1'b0;
        #1;
        check("async_rst_value", value, 24'h000000);
        step(); step();
        reset = 1'b1;
        ticks = 0; wraps = 0;
        for (int i = 0; i < 9; i++) begin
            step();
            if (tick) ticks++;
            if (day_wrap) wraps++;
        end
        check("post_rst_ticks", 24'(ticks), 24'd0);
        check("post_rst_wraps", 24'(wraps), 24'd0);
        step();
        check("post_rst_first_tick", {23'b0, tick}, 24'd1);
        check("post_rst_value", value, 24'h000001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
